// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-word holding buffer and baud_tick bit timing
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx_frame: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t              state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d, shift_q, shift_d;
    logic                hold_v_q, hold_v_d;
    logic                par_q, par_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                txd_q, txd_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                load;

    assign tx_ready = ready_q;
    assign txd      = txd_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE) | hold_v_q;

    // next-state: frame sequencing on baud_tick, shifter load from hold, handshake capture
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        load       = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    load  = hold_v_q;
                end
                START: begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q != CW'(DATA_BITS - 1)) begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else if (PARITY != 0) begin
                        txd_d   = par_q;
                        state_d = PAR;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end
                PAR: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
                STOP: begin
                    if (stop_cnt_q != 1'(STOP_BITS - 1)) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
                        load   = hold_v_q;
                        txd_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
        if (load) begin
            shift_d  = hold_q;
            par_d    = (PARITY == 2) ? ^hold_q : ~^hold_q;
            txd_d    = 1'b0;
            state_d  = START;
            hold_v_d = 1'b0;
        end
        if (tx_valid && ready_q) begin
            hold_d   = tx_data;
            hold_v_d = 1'b1;
        end
        ready_d = !hold_v_d;
    end

    // state register; reset aborts any frame and drops the pending word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for 8N1, 7E2 and 8O1 instances of uart_tx_frame
module tb_uart_tx_frame;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tick_en = 1'b1;
    int         tcnt = 0;
    logic [8:0] tx_data_a [3];
    logic [2:0] tx_valid = '0;
    logic [2:0] ready_v, txd_v, busy_v, done_v;
    logic [15:0] rx_a [3];
    logic [15:0] frame_a [3];
    int         rxn_a [3];
    int         len_a [3];
    int         done_cnt_a [3];
    int         done_tick_a [3];
    int         done_prev_a [3];
    int         n_checks = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // one-clk tick every 16 clk, changed 2 time units after posedge
    always begin
        @(posedge clk);
        #2;
        tcnt = (tcnt == 15) ? 0 : tcnt + 1;
        baud_tick = tick_en && (tcnt == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DB = (g == 1) ? 7 : 8;
        localparam int PB = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int SB = (g == 1) ? 2 : 1;
        logic [2:0]    q [$];
        logic [2:0]    e;
        logic [DB-1:0] d;
        logic          hold_m = 1'b0, pend = 1'b0, cur = 1'b1, r, t, acc, exp_done;
        int            tick_n = 0;

        uart_tx_frame #(.DATA_BITS(DB), .PARITY(PB), .STOP_BITS(SB)) dut (
            .clk(clk), .rst(rst), .baud_tick(baud_tick),
            .tx_data(tx_data_a[g][DB-1:0]), .tx_valid(tx_valid[g]),
            .tx_ready(ready_v[g]), .txd(txd_v[g]), .busy(busy_v[g]), .done(done_v[g])
        );

        initial begin
            rx_a[g] = '0; frame_a[g] = '0; rxn_a[g] = 0; len_a[g] = 0;
            done_cnt_a[g] = 0; done_tick_a[g] = 0; done_prev_a[g] = 0;
        end

        // scoreboard: queue holds {first, last, bit} per expected line bit
        always begin
            @(posedge clk);
            r = rst; t = baud_tick; acc = tx_valid[g] & !hold_m; d = tx_data_a[g][DB-1:0];
            #1;
            exp_done = 1'b0;
            if (r) begin
                q.delete(); hold_m = 1'b0; pend = 1'b0; cur = 1'b1;
            end else begin
                if (t) begin
                    tick_n++;
                    exp_done = pend;
                    pend = 1'b0;
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        cur = e[0];
                        if (e[2]) begin hold_m = 1'b0; rx_a[g] = '0; rxn_a[g] = 0; end
                        rx_a[g] = {rx_a[g][14:0], txd_v[g]};
                        rxn_a[g]++;
                        if (e[1]) begin pend = 1'b1; frame_a[g] = rx_a[g]; len_a[g] = rxn_a[g]; end
                    end else cur = 1'b1;
                end
                if (acc) begin
                    q.push_back(3'b100);
                    for (int i = 0; i < DB; i++) q.push_back({2'b00, d[i]});
                    if (PB != 0) q.push_back({2'b00, (PB == 2) ? ^d : ~^d});
                    for (int s = 0; s < SB; s++) q.push_back({1'b0, s == SB - 1, 1'b1});
                    hold_m = 1'b1;
                end
            end
            if (done_v[g]) begin
                done_cnt_a[g]++;
                done_prev_a[g] = done_tick_a[g];
                done_tick_a[g] = tick_n;
            end
            chk($sformatf("u%0d txd", g), {31'b0, txd_v[g]}, {31'b0, cur});
            chk($sformatf("u%0d ready", g), {31'b0, ready_v[g]}, {31'b0, !hold_m});
            chk($sformatf("u%0d busy", g), {31'b0, busy_v[g]}, {31'b0, (q.size() != 0) || pend});
            chk($sformatf("u%0d done", g), {31'b0, done_v[g]}, {31'b0, exp_done});
        end
    end

    task automatic send(input int g, input logic [8:0] w);
        int n = 0;
        tx_valid[g] = 1'b1;
        tx_data_a[g] = w;
        while (!ready_v[g] && n < 2000) begin @(negedge clk); n++; end
        chk("send timeout", {31'b0, n < 2000}, 32'd1);
        @(negedge clk);
        tx_valid[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done_v[g] && n < 4000);
        chk("done timeout", {31'b0, n < 4000}, 32'd1);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin @(negedge clk); n++; end while (!baud_tick && n < 40);
    endtask

    initial begin
        int dc;
        int n;
        for (int i = 0; i < 3; i++) tx_data_a[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset txd", {29'b0, txd_v}, 32'h7);
        chk("reset ready", {29'b0, ready_v}, 32'h7);
        chk("reset busy", {29'b0, busy_v}, 32'h0);
        rst = 1'b0;
        // 8N1 0xA5, accepted on a tick clk so the start must wait for the next tick
        wait_tick();
        send(0, 9'h0A5);
        wait_done(0);
        chk("t1 frame", {16'b0, frame_a[0]}, 32'b0101001011);
        chk("t1 len", len_a[0], 32'd10);
        repeat (40) @(negedge clk);
        // 7E2 0x41 and 8O1 0xFF
        send(1, 9'h041);
        wait_done(1);
        chk("t2 frame", {16'b0, frame_a[1]}, 32'b01000001011);
        chk("t2 len", len_a[1], 32'd11);
        send(2, 9'h0FF);
        wait_done(2);
        chk("t3 frame", {16'b0, frame_a[2]}, 32'b01111111111);
        chk("t3 len", len_a[2], 32'd11);
        // back-to-back 0x55 then 0x0F
        dc = done_cnt_a[0];
        send(0, 9'h055);
        send(0, 9'h00F);
        chk("t4 overlap", done_cnt_a[0], dc);
        wait_done(0);
        chk("t4 first frame", {16'b0, frame_a[0]}, 32'b0101010101);
        wait_done(0);
        chk("t4 second frame", {16'b0, frame_a[0]}, 32'b0111100001);
        chk("t4 done spacing", done_tick_a[0] - done_prev_a[0], 32'd10);
        // reset during data bit 3
        send(0, 9'h0C3);
        n = 0;
        while (rxn_a[0] != 5 && n < 2000) begin @(negedge clk); n++; end
        chk("t5 reach bit3", {31'b0, n < 2000}, 32'd1);
        repeat (3) @(negedge clk);
        dc = done_cnt_a[0];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5 txd", {31'b0, txd_v[0]}, 32'd1);
        chk("t5 ready", {31'b0, ready_v[0]}, 32'd1);
        chk("t5 busy", {31'b0, busy_v[0]}, 32'd0);
        repeat (200) @(negedge clk);
        chk("t5 no done", done_cnt_a[0], dc);
        send(0, 9'h03C);
        wait_done(0);
        chk("t5 clean frame", {16'b0, frame_a[0]}, 32'b0001111001);
        // no ticks for 100 clk after accepting 0x12
        wait_tick();
        tick_en = 1'b0;
        send(0, 9'h012);
        repeat (100) @(negedge clk);
        chk("t6 txd", {31'b0, txd_v[0]}, 32'd1);
        chk("t6 ready", {31'b0, ready_v[0]}, 32'd0);
        chk("t6 busy", {31'b0, busy_v[0]}, 32'd1);
        tick_en = 1'b1;
        wait_done(0);
        chk("t6 frame", {16'b0, frame_a[0]}, 32'b0010010001);
        repeat (40) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
